// File: rtl/stove_pkg.sv
// Shared types for the stove controller family: top-level state and level width.
package stove_pkg;

    localparam int LVL_W = 4;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        IDLE   = 2'd1,
        ADJUST = 2'd2
    } state_t;

endpackage

// File: rtl/stove_multi_press_hold_detector.sv
// Button helper: rising-edge pulse plus a saturating hold counter that emits one long-press pulse per hold.
// A button found held when reset releases stays disarmed until it is seen low.
module press_hold_detector #(
    parameter int HOLD_CYCLES = 150000000
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_lvl,
    input  logic i_hold,
    output logic o_edge,
    output logic o_long
);
    localparam int CW = $clog2(HOLD_CYCLES + 1);

    logic          r_prev;
    logic          r_armed;
    logic [CW-1:0] r_cnt;
    logic          w_counting;

    assign w_counting = i_hold & r_armed;
    assign o_edge     = i_lvl & ~r_prev & r_armed;
    assign o_long     = w_counting & (r_cnt == CW'(HOLD_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_prev <= i_lvl;
            if (!i_lvl) begin
                r_armed <= 1'b1;
            end
            // Stops at HOLD_CYCLES so the long pulse cannot repeat within one hold.
            if (!w_counting) begin
                r_cnt <= '0;
            end else if (r_cnt != CW'(HOLD_CYCLES)) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/stove_multi.sv
// Multi-surface stove controller: on/off, one selected surface, per-surface power levels.
// Short and long presses on inc/dec, inactivity timeout; every output is a register.
module stove_multi
    import stove_pkg::*;
#(
    parameter int NUM_SURFACES   = 4,
    parameter int MAX_LEVEL      = 9,
    parameter int HOLD_CYCLES    = 150000000,
    parameter int TIMEOUT_CYCLES = 500000000
) (
    input  logic                      clk,
    input  logic                      async_reset,
    input  logic                      power_toggle,
    input  logic [NUM_SURFACES-1:0]   surface_toggle,
    input  logic                      power_level_inc,
    input  logic                      power_level_dec,
    output logic [4*NUM_SURFACES-1:0] levels,
    output logic [NUM_SURFACES-1:0]   selected,
    output logic                      powered
);
    localparam int               TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(MAX_LEVEL);

    state_t                  r_state;
    logic [NUM_SURFACES-1:0] r_sel;
    logic                    r_powered;
    logic [TW-1:0]           r_idle_cnt;

    logic                    w_inc_edge, w_inc_long;
    logic                    w_dec_edge, w_dec_long;
    logic                    w_unused_both_edge, w_both_long;
    logic                    w_inc_only, w_dec_only, w_both;
    logic [NUM_SURFACES-1:0] w_tog;
    logic                    w_active, w_timeout, w_all_zero;

    assign w_inc_only = power_level_inc & ~power_level_dec;
    assign w_dec_only = power_level_dec & ~power_level_inc;
    assign w_both     = power_level_inc & power_level_dec;

    press_hold_detector #(.HOLD_CYCLES(HOLD_CYCLES)) u_inc (
        .clk(clk), .i_rst_n(async_reset), .i_lvl(power_level_inc), .i_hold(w_inc_only),
        .o_edge(w_inc_edge), .o_long(w_inc_long)
    );
    press_hold_detector #(.HOLD_CYCLES(HOLD_CYCLES)) u_dec (
        .clk(clk), .i_rst_n(async_reset), .i_lvl(power_level_dec), .i_hold(w_dec_only),
        .o_edge(w_dec_edge), .o_long(w_dec_long)
    );
    press_hold_detector #(.HOLD_CYCLES(HOLD_CYCLES)) u_both (
        .clk(clk), .i_rst_n(async_reset), .i_lvl(w_both), .i_hold(w_both),
        .o_edge(w_unused_both_edge), .o_long(w_both_long)
    );

    // Isolate the lowest set toggle bit.
    assign w_tog      = surface_toggle & (~surface_toggle + NUM_SURFACES'(1));
    assign w_active   = power_toggle | (|surface_toggle) | power_level_inc | power_level_dec;
    assign w_timeout  = ~w_active & (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign w_all_zero = (levels == '0);

    assign selected = r_sel;
    assign powered  = r_powered;

    always_ff @(posedge clk) begin
        if (!async_reset) begin
            r_state    <= OFF;
            r_sel      <= '0;
            r_powered  <= 1'b0;
            r_idle_cnt <= '0;
        end else if (r_state == OFF) begin
            r_idle_cnt <= '0;
            if (power_toggle) begin
                r_state   <= IDLE;
                r_powered <= 1'b1;
            end
        end else begin
            if (w_active || w_timeout) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != TW'(TIMEOUT_CYCLES)) begin
                r_idle_cnt <= r_idle_cnt + TW'(1);
            end

            if (power_toggle) begin
                r_state   <= OFF;
                r_sel     <= '0;
                r_powered <= 1'b0;
            end else if (w_tog != '0) begin
                if ((w_tog & r_sel) != '0) begin
                    r_sel   <= '0;
                    r_state <= IDLE;
                end else begin
                    r_sel   <= w_tog;
                    r_state <= ADJUST;
                end
            end else if (w_timeout) begin
                if (r_state == ADJUST) begin
                    r_sel   <= '0;
                    r_state <= IDLE;
                end else if (w_all_zero) begin
                    r_state   <= OFF;
                    r_powered <= 1'b0;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_SURFACES; i++) begin : g_surf
        logic [LVL_W-1:0] r_lvl;

        assign levels[LVL_W*i +: LVL_W] = r_lvl;

        // Adjustments target the selection held at the start of the cycle.
        always_ff @(posedge clk) begin
            if (!async_reset) begin
                r_lvl <= '0;
            end else if (r_state != OFF && power_toggle) begin
                r_lvl <= '0;
            end else if (r_state == ADJUST) begin
                if (w_both_long) begin
                    r_lvl <= '0;
                end else if (r_sel[i]) begin
                    if (w_inc_long) begin
                        r_lvl <= MAX_LVL;
                    end else if (w_dec_long) begin
                        r_lvl <= '0;
                    end else if (w_inc_edge && !w_dec_edge && r_lvl != MAX_LVL) begin
                        r_lvl <= r_lvl + LVL_W'(1);
                    end else if (w_dec_edge && !w_inc_edge && r_lvl != '0) begin
                        r_lvl <= r_lvl - LVL_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_stove_multi.sv
// Scoreboard bench for stove_multi: directed scenarios plus randomized traffic against a behavioural model.
module tb_stove_multi;
    localparam int NS   = 4;
    localparam int MAXL = 9;
    localparam int HOLD = 8;
    localparam int TMO  = 20;

    logic            clk = 1'b0;
    logic            async_reset;
    logic            power_toggle;
    logic [NS-1:0]   surface_toggle;
    logic            power_level_inc;
    logic            power_level_dec;
    logic [4*NS-1:0] levels;
    logic [NS-1:0]   selected;
    logic            powered;

    stove_multi #(
        .NUM_SURFACES(NS), .MAX_LEVEL(MAXL), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .async_reset(async_reset), .power_toggle(power_toggle),
        .surface_toggle(surface_toggle), .power_level_inc(power_level_inc),
        .power_level_dec(power_level_dec), .levels(levels), .selected(selected),
        .powered(powered)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            pw;
        logic [NS-1:0]   sel;
        logic [4*NS-1:0] lv;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Behavioural model state
    bit m_on;
    int m_sel;
    int m_lvl[NS];
    bit m_pi, m_pd;
    bit m_ai, m_ad, m_ab;
    int m_kind, m_len, m_idle;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit pt, input logic [NS-1:0] st,
                              input bit inc, input bit dec);
        bit ei, ed, armed, lng_i, lng_d, lng_b, act, tmo, allz;
        int kind_now, nl, lo;
        if (!rst) begin
            m_on = 0; m_sel = -1;
            for (int i = 0; i < NS; i++) m_lvl[i] = 0;
            m_pi = 0; m_pd = 0; m_ai = 0; m_ad = 0; m_ab = 0;
            m_kind = 0; m_len = 0; m_idle = 0;
            return;
        end
        ei = inc && !m_pi && m_ai;
        ed = dec && !m_pd && m_ad;
        kind_now = (inc && !dec) ? 1 : (dec && !inc) ? 2 : (inc && dec) ? 3 : 0;
        armed = (kind_now == 1) ? m_ai : (kind_now == 2) ? m_ad : (kind_now == 3) ? m_ab : 1'b0;
        lng_i = 0; lng_d = 0; lng_b = 0;
        if (kind_now != 0 && armed) begin
            nl = (kind_now == m_kind) ? ((m_len < HOLD + 1) ? m_len + 1 : m_len) : 1;
            m_kind = kind_now;
            m_len = nl;
            if (nl == HOLD) begin
                lng_i = (kind_now == 1);
                lng_d = (kind_now == 2);
                lng_b = (kind_now == 3);
            end
        end else begin
            m_kind = 0;
            m_len = 0;
        end
        m_ai = m_ai | !inc;
        m_ad = m_ad | !dec;
        m_ab = m_ab | !(inc && dec);
        m_pi = inc;
        m_pd = dec;

        act = pt || (st != 0) || inc || dec;
        tmo = 0;
        if (!m_on || act) begin
            m_idle = 0;
        end else begin
            m_idle++;
            if (m_idle == TMO) begin
                tmo = 1;
                m_idle = 0;
            end
        end

        if (!m_on) begin
            if (pt) m_on = 1;
        end else if (pt) begin
            m_on = 0; m_sel = -1;
            for (int i = 0; i < NS; i++) m_lvl[i] = 0;
        end else begin
            if (m_sel >= 0) begin
                if (lng_b) begin
                    for (int i = 0; i < NS; i++) m_lvl[i] = 0;
                end else if (lng_i) m_lvl[m_sel] = MAXL;
                else if (lng_d) m_lvl[m_sel] = 0;
                else if (ei && !ed && m_lvl[m_sel] < MAXL) m_lvl[m_sel]++;
                else if (ed && !ei && m_lvl[m_sel] > 0) m_lvl[m_sel]--;
            end
            if (st != 0) begin
                lo = 0;
                for (int i = NS - 1; i >= 0; i--) if (st[i]) lo = i;
                m_sel = (lo == m_sel) ? -1 : lo;
            end else if (tmo) begin
                if (m_sel >= 0) begin
                    m_sel = -1;
                end else begin
                    allz = 1;
                    for (int i = 0; i < NS; i++) if (m_lvl[i] != 0) allz = 0;
                    if (allz) m_on = 0;
                end
            end
        end
    endtask

    task automatic step(input bit rst, input bit pt, input logic [NS-1:0] st,
                        input bit inc, input bit dec);
        exp_t e;
        @(negedge clk);
        async_reset = rst; power_toggle = pt; surface_toggle = st;
        power_level_inc = inc; power_level_dec = dec;
        model_step(rst, pt, st, inc, dec);
        e.pw  = m_on;
        e.sel = (m_sel >= 0) ? (NS'(1) << m_sel) : '0;
        for (int i = 0; i < NS; i++) e.lv[4*i +: 4] = 4'(m_lvl[i]);
        exp_q.push_back(e);
    endtask

    task automatic press_inc(input int n);
        repeat (n) begin step(1, 0, '0, 1, 0); step(1, 0, '0, 0, 0); end
    endtask

    task automatic press_dec(input int n);
        repeat (n) begin step(1, 0, '0, 0, 1); step(1, 0, '0, 0, 0); end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1, 0, '0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, '0, 0, 0);
        step(0, 0, '0, 0, 0);
    endtask

    // Fixed expectations taken straight from the scenario descriptions.
    task automatic expect_now(input string name, input logic pw, input logic [NS-1:0] sel,
                              input logic [4*NS-1:0] lv);
        @(posedge clk);
        #1;
        chk({name, "_powered"}, 32'(powered), 32'(pw));
        chk({name, "_selected"}, 32'(selected), 32'(sel));
        chk({name, "_levels"}, 32'(levels), 32'(lv));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_powered", 32'(powered), 32'(e.pw));
                chk("sb_selected", 32'(selected), 32'(e.sel));
                chk("sb_levels", 32'(levels), 32'(e.lv));
            end
        end
    end

    initial begin : driver
        bit quiet, ri, rd, rr, rp;
        logic [NS-1:0] rs;
        async_reset = 0; power_toggle = 0; surface_toggle = '0;
        power_level_inc = 0; power_level_dec = 0;
        model_step(0, 0, '0, 0, 0);

        // Power on, select surface 2, three short presses
        do_reset();
        expect_now("reset", 1'b0, 4'b0000, 16'h0000);
        step(1, 1, '0, 0, 0);
        step(1, 0, 4'b0100, 0, 0);
        press_inc(3);
        expect_now("s1", 1'b1, 4'b0100, 16'h0300);

        // Saturation at both ends
        do_reset();
        step(1, 1, '0, 0, 0);
        step(1, 0, 4'b0001, 0, 0);
        press_inc(8);
        expect_now("s2_eight", 1'b1, 4'b0001, 16'h0008);
        press_inc(2);
        expect_now("s2_max", 1'b1, 4'b0001, 16'h0009);
        press_dec(12);
        expect_now("s2_zero", 1'b1, 4'b0001, 16'h0000);

        // Long inc press, then continued holding
        do_reset();
        step(1, 1, '0, 0, 0);
        step(1, 0, 4'b0010, 0, 0);
        repeat (HOLD) step(1, 0, '0, 1, 0);
        expect_now("s3_long", 1'b1, 4'b0010, 16'h0090);
        repeat (20) step(1, 0, '0, 1, 0);
        expect_now("s3_hold", 1'b1, 4'b0010, 16'h0090);
        step(1, 0, '0, 0, 0);

        // Build 0x1234, then clear all with a both-held long press
        do_reset();
        step(1, 1, '0, 0, 0);
        step(1, 0, 4'b0001, 0, 0); press_inc(4);
        step(1, 0, 4'b0010, 0, 0); press_inc(3);
        step(1, 0, 4'b0100, 0, 0); press_inc(2);
        step(1, 0, 4'b1000, 0, 0); press_inc(1);
        expect_now("s4_build", 1'b1, 4'b1000, 16'h1234);
        repeat (HOLD) step(1, 0, '0, 1, 1);
        expect_now("s4_clear", 1'b1, 4'b1000, 16'h0000);

        // Inactivity: deselect, then power off
        idle(TMO - 1);
        expect_now("s5_pre_deselect", 1'b1, 4'b1000, 16'h0000);
        idle(1);
        expect_now("s5_deselect", 1'b1, 4'b0000, 16'h0000);
        idle(TMO - 1);
        expect_now("s5_pre_off", 1'b1, 4'b0000, 16'h0000);
        idle(1);
        expect_now("s5_off", 1'b0, 4'b0000, 16'h0000);

        // Multi-bit toggle, reset mid-hold with inc still held
        do_reset();
        step(1, 1, '0, 0, 0);
        step(1, 0, 4'b1010, 0, 0);
        expect_now("s6_lowest", 1'b1, 4'b0010, 16'h0000);
        repeat (4) step(1, 0, '0, 1, 0);
        step(0, 0, '0, 1, 0);
        step(0, 0, '0, 1, 0);
        expect_now("s6_reset", 1'b0, 4'b0000, 16'h0000);
        repeat (3) step(1, 0, '0, 1, 0);
        step(1, 1, '0, 1, 0);
        step(1, 0, 4'b0010, 1, 0);
        repeat (12) step(1, 0, '0, 1, 0);
        expect_now("s6_no_action", 1'b1, 4'b0010, 16'h0000);
        step(1, 0, '0, 0, 0);
        press_inc(1);
        expect_now("s6_repress", 1'b1, 4'b0010, 16'h0010);

        // Randomized traffic with quiet stretches to exercise timeouts
        quiet = 0; ri = 0; rd = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) quiet = ($urandom_range(0, 2) == 0);
            if (quiet) begin
                ri = 0; rd = 0;
                step(1, 0, '0, 0, 0);
            end else begin
                rr = ($urandom_range(0, 199) != 0);
                rp = ($urandom_range(0, 39) == 0);
                rs = ($urandom_range(0, 7) == 0) ? NS'($urandom_range(1, 15)) : '0;
                if ($urandom_range(0, 5) == 0) ri = ~ri;
                if ($urandom_range(0, 5) == 0) rd = ~rd;
                step(rr, rp, rs, ri, rd);
            end
        end

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
